pooling_window_max: RTL and testbench

Upstream stage of the pooling layer. It consumes the raster-ordered pixel stream of each convolution feature map and computes the maximum of every non-overlapping KERNEL_SIZE×KERNEL_SIZE window on IEEE-754 single-precision values. It emits one pooled value per window, tagged with feature index, pooled row and pooled column, for the pooling output buffering stage. Horizontal maxima are built on the fly; vertical maxima use a one-row line buffer of partial results.

---
 rtl/pooling_window_max.sv | 208 ++++++++++++++++++++
 tb/tb_pooling_window_max.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_window_max.sv
// Max pooling of non-overlapping KERNEL_SIZE x KERNEL_SIZE windows over a raster float32 pixel stream.
// Latency: output_valid one cycle after the input_valid of a window's bottom-right pixel.
// Backpressure: none offered; gaps in input_valid stall every counter and register.
// Ports: clk, rst_n, start, data_in/input_valid in; data_out/output_valid with feature_idx,
//        feature_row, feature_col tags, plus busy (frame in progress) and done (frame finished) out.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pooling_window_max #(
    parameter int KERNEL_SIZE   = 2,
    parameter int INPUT_SIZE    = 6,
    parameter int TOTAL_FEATURE = 4,
    parameter int FEATURE_WIDTH = 2,
    parameter int ROW_WIDTH     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [`DATA_WIDTH-1:0]   data_in,
    input  logic                     input_valid,
    output logic [`DATA_WIDTH-1:0]   data_out,
    output logic                     output_valid,
    output logic [FEATURE_WIDTH-1:0] feature_idx,
    output logic [ROW_WIDTH-1:0]     feature_row,
    output logic [ROW_WIDTH-1:0]     feature_col,
    output logic                     busy,
    output logic                     done
);
    localparam int DW          = `DATA_WIDTH;
    localparam int OUTPUT_SIZE = INPUT_SIZE / KERNEL_SIZE;

    localparam logic [ROW_WIDTH-1:0]     LAST_PIX = ROW_WIDTH'(INPUT_SIZE - 1);
    localparam logic [ROW_WIDTH-1:0]     LAST_K   = ROW_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [ROW_WIDTH-1:0]     OS       = ROW_WIDTH'(OUTPUT_SIZE);
    localparam logic [ROW_WIDTH-1:0]     ONE_R    = ROW_WIDTH'(1);
    localparam logic [FEATURE_WIDTH-1:0] LAST_F   = FEATURE_WIDTH'(TOTAL_FEATURE - 1);
    localparam logic [FEATURE_WIDTH-1:0] ONE_F    = FEATURE_WIDTH'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [ROW_WIDTH-1:0]     col_q, col_d, row_q, row_d;
    logic [ROW_WIDTH-1:0]     kx_q, kx_d, ky_q, ky_d;
    logic [ROW_WIDTH-1:0]     gx_q, gx_d, gy_q, gy_d;
    logic [FEATURE_WIDTH-1:0] feat_q, feat_d;
    logic                     done_d;

    logic [DW-1:0]            hmax_q;
    logic [DW-1:0]            lbuf_q [OUTPUT_SIZE];
    logic [DW-1:0]            h, lbuf_sel, win;
    logic                     accept, grp_vld, col_end, emit;

    logic [DW-1:0]            data_out_q;
    logic                     output_valid_q, done_q;
    logic [FEATURE_WIDTH-1:0] feature_idx_q;
    logic [ROW_WIDTH-1:0]     feature_row_q, feature_col_q;

    // Float max on raw bits; a is the stored operand and is kept on ties.
    // Opposite signs: the non-negative one wins (so +0 beats -0).
    // Same sign: compare magnitudes, inverted for negatives.
    function automatic logic [DW-1:0] fmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic b_wins;
        if (a[DW-1] != b[DW-1])
            b_wins = ~b[DW-1];
        else if (!a[DW-1])
            b_wins = (b[DW-2:0] > a[DW-2:0]);
        else
            b_wins = (b[DW-2:0] < a[DW-2:0]);
        return b_wins ? b : a;
    endfunction

    assign accept  = (state_q == RUN) && input_valid;
    // Tail columns/rows leave gx/gy parked at OUTPUT_SIZE, which masks all updates.
    assign grp_vld = (gx_q < OS) && (gy_q < OS);
    // First pixel of a horizontal group bypasses the stale hmax (also makes K=1 work).
    assign h       = (kx_q == '0) ? data_in : fmax(hmax_q, data_in);
    assign win     = (ky_q == '0) ? h : fmax(lbuf_sel, h);
    assign col_end = accept && (kx_q == LAST_K) && grp_vld;
    assign emit    = col_end && (ky_q == LAST_K);

    always_comb begin
        lbuf_sel = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++)
            if (gx_q == ROW_WIDTH'(i)) lbuf_sel = lbuf_q[i];
    end

    // Next state and raster counters.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        feat_d  = feat_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                    feat_d  = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                    gx_d    = '0;
                    gy_d    = '0;
                end
            end
            RUN: begin
                if (input_valid) begin
                    if (col_q == LAST_PIX) begin
                        col_d = '0;
                        kx_d  = '0;
                        gx_d  = '0;
                        if (row_q == LAST_PIX) begin
                            row_d  = '0;
                            ky_d   = '0;
                            gy_d   = '0;
                            feat_d = feat_q + ONE_F;
                            if (feat_q == LAST_F) begin
                                feat_d  = '0;
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            row_d = row_q + ONE_R;
                            if (ky_q == LAST_K) begin
                                ky_d = '0;
                                if (gy_q < OS) gy_d = gy_q + ONE_R;
                            end else begin
                                ky_d = ky_q + ONE_R;
                            end
                        end
                    end else begin
                        col_d = col_q + ONE_R;
                        if (kx_q == LAST_K) begin
                            kx_d = '0;
                            if (gx_q < OS) gx_d = gx_q + ONE_R;
                        end else begin
                            kx_d = kx_q + ONE_R;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            feat_q         <= '0;
            kx_q           <= '0;
            ky_q           <= '0;
            gx_q           <= '0;
            gy_q           <= '0;
            hmax_q         <= '0;
            done_q         <= 1'b0;
            output_valid_q <= 1'b0;
            data_out_q     <= '0;
            feature_idx_q  <= '0;
            feature_row_q  <= '0;
            feature_col_q  <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            feat_q         <= feat_d;
            kx_q           <= kx_d;
            ky_q           <= ky_d;
            gx_q           <= gx_d;
            gy_q           <= gy_d;
            done_q         <= done_d;
            output_valid_q <= emit;
            if (accept) hmax_q <= h;
            if (emit) begin
                data_out_q    <= win;
                feature_idx_q <= feat_q;
                feature_row_q <= gy_q;
                feature_col_q <= gx_q;
            end
        end
    end

    // Line buffer of partial vertical maxima, one entry per pooled column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) lbuf_q[i] <= '0;
        end else if (col_end) begin
            for (int i = 0; i < OUTPUT_SIZE; i++)
                if (gx_q == ROW_WIDTH'(i)) lbuf_q[i] <= win;
        end
    end

    assign data_out     = data_out_q;
    assign output_valid = output_valid_q;
    assign feature_idx  = feature_idx_q;
    assign feature_row  = feature_row_q;
    assign feature_col  = feature_col_q;
    assign busy         = (state_q == RUN);
    assign done         = done_q;

endmodule

// File: tb/tb_pooling_window_max.sv
// Bench for pooling_window_max: 6x6/4-feature instance (a) and 5x5/1-feature instance (b).
// Pixels are integers (kept as ordering keys, -0 below +0) converted to float32; the reference
// takes the largest key of each window, and a monitor pops expected outputs from a queue.
module tb_pooling_window_max;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, vld_a, ov_a, busy_a, done_a;
    logic [31:0] din_a, dout_a;
    logic [1:0]  fidx_a;
    logic [2:0]  frow_a, fcol_a;
    logic        start_b, vld_b, ov_b, busy_b, done_b;
    logic [31:0] din_b, dout_b;
    logic [1:0]  fidx_b;
    logic [2:0]  frow_b, fcol_b;

    pooling_window_max #(.KERNEL_SIZE(2), .INPUT_SIZE(6), .TOTAL_FEATURE(4),
                         .FEATURE_WIDTH(2), .ROW_WIDTH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(din_a), .input_valid(vld_a),
        .data_out(dout_a), .output_valid(ov_a), .feature_idx(fidx_a), .feature_row(frow_a),
        .feature_col(fcol_a), .busy(busy_a), .done(done_a));

    pooling_window_max #(.KERNEL_SIZE(2), .INPUT_SIZE(5), .TOTAL_FEATURE(1),
                         .FEATURE_WIDTH(2), .ROW_WIDTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(din_b), .input_valid(vld_b),
        .data_out(dout_b), .output_valid(ov_b), .feature_idx(fidx_b), .feature_row(frow_b),
        .feature_col(fcol_b), .busy(busy_b), .done(done_b));

    typedef struct {
        logic [31:0] d;
        int          f;
        int          r;
        int          c;
        int          cy;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pk[4][6][6];
    int   done_cnt[2];
    int   done_cyc[2];
    int   out_cnt[2];
    logic busy_at_done[2];
    logic busy_pre_done[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Key encoding: 0 is -0.0, 1 is +0.0, any even key 2v is the integer v.
    function automatic logic [31:0] tofloat(input int key);
        int   v, m, e;
        logic s;
        if (key == 0) return 32'h8000_0000;
        if (key == 1) return 32'h0000_0000;
        v = key / 2;
        s = (v < 0);
        m = s ? -v : v;
        e = 0;
        for (int i = 0; i < 24; i++) if (m >= (1 << i)) e = i;
        return {s, 8'(127 + e), 23'((m << (23 - e)) & 32'h007f_ffff)};
    endfunction

    function automatic int rand_key();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 1));
        return 2 * (int'($urandom_range(0, 2000)) - 1000);
    endfunction

    task automatic chk_pop(input int inst, input logic [31:0] d, input logic [31:0] f,
                           input logic [31:0] r, input logic [31:0] c);
        exp_t e;
        n_tests++;
        if ((inst == 0 ? qa.size() : qb.size()) == 0) begin
            n_fail++;
            $display("FAIL unexpected_output inst%0d: got %h tag (%0d,%0d,%0d), required no output",
                     inst, d, f, r, c);
            return;
        end
        if (inst == 0) e = qa.pop_front();
        else e = qb.pop_front();
        check("out_data", d, e.d);
        check("out_feature", f, 32'(e.f));
        check("out_row", r, 32'(e.r));
        check("out_col", c, 32'(e.c));
        check("out_cycle", 32'(cyc), 32'(e.cy));
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic pb_a, pb_b;
        pb_a = 1'b0;
        pb_b = 1'b0;
        forever begin
            @(negedge clk);
            if (ov_a) begin
                out_cnt[0]++;
                chk_pop(0, dout_a, 32'(fidx_a), 32'(frow_a), 32'(fcol_a));
            end
            if (ov_b) begin
                out_cnt[1]++;
                chk_pop(1, dout_b, 32'(fidx_b), 32'(frow_b), 32'(fcol_b));
            end
            if (done_a) begin
                done_cnt[0]++; done_cyc[0] = cyc; busy_at_done[0] = busy_a; busy_pre_done[0] = pb_a;
            end
            if (done_b) begin
                done_cnt[1]++; done_cyc[1] = cyc; busy_at_done[1] = busy_b; busy_pre_done[1] = pb_b;
            end
            pb_a = busy_a;
            pb_b = busy_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int inst, input logic st, input logic v, input logic [31:0] d);
        if (inst == 0) begin start_a = st; vld_a = v; din_a = d; end
        else begin start_b = st; vld_b = v; din_b = d; end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_data_out"}, dout_a, 32'h0);
        check({tag, "_output_valid"}, 32'(ov_a), 32'h0);
        check({tag, "_feature_idx"}, 32'(fidx_a), 32'h0);
        check({tag, "_feature_row"}, 32'(frow_a), 32'h0);
        check({tag, "_feature_col"}, 32'(fcol_a), 32'h0);
        check({tag, "_busy"}, 32'(busy_a), 32'h0);
        check({tag, "_done"}, 32'(done_a), 32'h0);
    endtask

    // kind: 0 ramp 100f+IS*r+c, 1 negative ramp with pixel (0,0)=zkey, 2 random,
    //       3 random with window {-5,3,-1,2}, 4 random with window {-5,-3,-1,-2}.
    task automatic send_frame(input int inst, input int kind, input int zkey, input int gapmax,
                              input int start_mid, input int abort_at);
        int   is, nf, os, k, dc0, last_cyc, m;
        exp_t e;
        is = (inst == 0) ? 6 : 5;
        nf = (inst == 0) ? 4 : 1;
        os = is / 2;
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < is; r++)
                for (int c = 0; c < is; c++)
                    case (kind)
                        0:       pk[f][r][c] = 2 * (100 * f + is * r + c);
                        1:       pk[f][r][c] = (r == 0 && c == 0) ? zkey : -2 * (is * r + c);
                        default: pk[f][r][c] = rand_key();
                    endcase
        if (kind == 3) begin
            pk[0][0][0] = -10; pk[0][0][1] = 6; pk[0][1][0] = -2; pk[0][1][1] = 4;
        end
        if (kind == 4) begin
            pk[0][0][0] = -10; pk[0][0][1] = -6; pk[0][1][0] = -2; pk[0][1][1] = -4;
        end
        dc0 = done_cnt[inst];
        last_cyc = 0;
        tick();
        drive(inst, 1'b1, 1'b0, 32'h0);
        tick();
        drive(inst, 1'b0, 1'b0, 32'h0);
        check("busy_after_start", 32'(inst == 0 ? busy_a : busy_b), 32'h1);
        k = 0;
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < is; r++)
                for (int c = 0; c < is; c++) begin
                    if (k == abort_at) begin
                        tick();
                        drive(inst, 1'b0, 1'b0, 32'h0);
                        #2 rst_n = 1'b0;
                        @(negedge clk);
                        check_reset_a("abort");
                        check("abort_no_pending", 32'(qa.size()), 32'h0);
                        tick();
                        rst_n = 1'b1;
                        return;
                    end
                    repeat ($urandom_range(0, gapmax)) begin
                        tick();
                        drive(inst, 1'b0, 1'b0, $urandom);
                    end
                    tick();
                    drive(inst, (k == start_mid), 1'b1, tofloat(pk[f][r][c]));
                    last_cyc = cyc;
                    if (r % 2 == 1 && c % 2 == 1 && r < 2 * os && c < 2 * os) begin
                        m = pk[f][r][c];
                        for (int y = r - 1; y <= r; y++)
                            for (int x = c - 1; x <= c; x++)
                                if (pk[f][y][x] > m) m = pk[f][y][x];
                        e.d = tofloat(m); e.f = f; e.r = r / 2; e.c = c / 2; e.cy = cyc + 1;
                        if (inst == 0) qa.push_back(e);
                        else qb.push_back(e);
                    end
                    k++;
                end
        tick();
        drive(inst, 1'b0, 1'b0, 32'h0);
        repeat (4) tick();
        check("done_count", 32'(done_cnt[inst] - dc0), 32'h1);
        check("done_cycle", 32'(done_cyc[inst]), 32'(last_cyc + 1));
        check("busy_at_done", 32'(busy_at_done[inst]), 32'h0);
        check("busy_before_done", 32'(busy_pre_done[inst]), 32'h1);
    endtask

    initial begin
        int o0, d0;
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0; done_cyc[i] = 0; out_cnt[i] = 0;
            busy_at_done[i] = 1'b0; busy_pre_done[i] = 1'b0;
        end
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_a("reset");
        check("reset_b_busy", 32'(busy_b), 32'h0);

        send_frame(0, 0, 0, 0, -1, -1);          // ramp, back-to-back
        send_frame(0, 1, 0, 0, -1, -1);          // negative ramp, (0,0) = -0.0
        send_frame(0, 1, 1, 0, -1, -1);          // negative ramp, (0,0) = +0.0
        send_frame(0, 3, 0, 3, -1, -1);          // mixed-sign window with gaps
        send_frame(0, 4, 0, 3, -1, -1);          // all-negative window with gaps
        send_frame(0, 2, 0, 2, 50, -1);          // random, start pulsed mid-frame

        // input_valid with no start must not produce anything
        o0 = out_cnt[0];
        d0 = done_cnt[0];
        repeat (20) begin
            tick();
            drive(0, 1'b0, 1'b1, $urandom);
        end
        tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        check("idle_no_output", 32'(out_cnt[0] - o0), 32'h0);
        check("idle_no_done", 32'(done_cnt[0] - d0), 32'h0);
        check("idle_busy", 32'(busy_a), 32'h0);

        send_frame(0, 0, 0, 0, -1, 21);          // reset mid-row 3
        send_frame(0, 0, 0, 1, -1, -1);          // clean restart after abort
        send_frame(1, 0, 0, 0, -1, -1);          // odd size ramp 5r+c
        send_frame(1, 2, 0, 2, -1, -1);          // odd size random

        repeat (3) tick();
        check("queue_a_drained", 32'(qa.size()), 32'h0);
        check("queue_b_drained", 32'(qb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
